// File: rtl/fetch_unit.sv
// fetch_unit: sequential 16-bit instruction fetch with a one-entry skid buffer,
// branch redirect and halt-word detection.
module fetch_unit #(
    parameter int          NS        = 15,
    parameter int          DEPTH     = 64,
    parameter logic [NS:0] RESET_PC  = '0,
    parameter logic [15:0] HALT_WORD = 16'hEFFF
) (
    input  logic        clk,
    input  logic        rst,
    output logic [NS:0] pc_out,
    input  logic [15:0] instr_in,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [NS:0] branch_target,
    output logic [15:0] instr_out,
    output logic [NS:0] instr_pc,
    output logic        instr_valid,
    output logic        halted
);
    localparam logic [NS:0] SPAN = (NS+1)'(2 * DEPTH);
    localparam logic [NS:0] TWO  = (NS+1)'(2);

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
    state_t state, state_nx;

    logic        fl_v, sk_v;
    logic [NS:0] fl_pc, sk_pc;
    logic [15:0] sk_w;

    logic        accept, ld_v, halt_ld, sk_nx, sk_wr, issue;
    logic [15:0] ld_w;
    logic [NS:0] ld_pc, pc_inc, tgt;

    // The skid always drains ahead of the in-flight word, so fetch order is kept.
    always_comb begin
        accept   = !instr_valid || !stall;
        ld_v     = sk_v || fl_v;
        ld_w     = sk_v ? sk_w : instr_in;
        ld_pc    = sk_v ? sk_pc : fl_pc;
        halt_ld  = accept && ld_v && ld_w == HALT_WORD && !branch_taken;
        sk_nx    = accept ? (sk_v && fl_v) : (sk_v || fl_v);
        sk_wr    = fl_v && (accept == sk_v);
        issue    = !sk_nx && !halt_ld;
        pc_inc   = (pc_out == SPAN - TWO) ? '0 : pc_out + TWO;
        tgt      = (branch_target & ~((NS+1)'(1))) % SPAN;
        state_nx = (state == HALT || halt_ld) ? HALT : RUN;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= BOOT;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_out      <= RESET_PC;
            instr_out   <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            fl_v        <= 1'b0;
            fl_pc       <= '0;
            sk_v        <= 1'b0;
            sk_w        <= '0;
            sk_pc       <= '0;
        end else if (state == HALT) begin
            fl_v <= 1'b0;
            sk_v <= 1'b0;
            if (instr_valid && !stall)
                instr_valid <= 1'b0;
        end else if (branch_taken) begin
            pc_out      <= tgt;
            instr_valid <= 1'b0;
            fl_v        <= 1'b0;
            sk_v        <= 1'b0;
        end else begin
            if (accept) begin
                instr_valid <= ld_v;
                if (ld_v) begin
                    instr_out <= ld_w;
                    instr_pc  <= ld_pc;
                end
            end
            sk_v <= sk_nx;
            if (sk_wr) begin
                sk_w  <= instr_in;
                sk_pc <= fl_pc;
            end
            fl_v <= issue;
            if (issue) begin
                fl_pc  <= pc_out;
                pc_out <= pc_inc;
            end
        end
    end

    assign halted = state == HALT && !instr_valid;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch order, stall/skid, branch, wrap, halt and reset.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst, stall, branch_taken;
    logic [15:0] pc_out, instr_in, instr_out, instr_pc, branch_target;
    logic        instr_valid, halted;
    logic [15:0] mem [64];
    int          total = 0, bad = 0;

    fetch_unit dut (
        .clk(clk), .rst(rst), .pc_out(pc_out), .instr_in(instr_in),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .halted(halted)
    );

    always #5 clk = ~clk;
    always @(posedge clk) instr_in <= mem[pc_out[6:1]];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    task automatic out_chk(input string tag, input logic v, input logic [15:0] w, input logic [15:0] p);
        chk({tag, ".valid"}, 32'(instr_valid), 32'(v));
        if (v) begin
            chk({tag, ".instr"}, 32'(instr_out), 32'(w));
            chk({tag, ".pc"}, 32'(instr_pc), 32'(p));
        end
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, ".pc_out"}, 32'(pc_out), 32'h0);
        chk({tag, ".instr"}, 32'(instr_out), 32'h0);
        chk({tag, ".ipc"}, 32'(instr_pc), 32'h0);
        chk({tag, ".valid"}, 32'(instr_valid), 32'h0);
        chk({tag, ".halted"}, 32'(halted), 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'h1000 + 16'(i);
        mem[0] = 16'hF120; mem[1] = 16'hF121; mem[2] = 16'h93FF;
        mem[3] = 16'h834C; mem[4] = 16'hF564; mem[6] = 16'hFFF1;
        mem[27] = 16'hEFFF;
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        tick(); tick();
        rst_chk("reset");
        rst = 1'b0;
        tick(); chk("c1.pc_out", 32'(pc_out), 32'h2); out_chk("c1", 1'b0, 0, 0);
        tick(); chk("c2.pc_out", 32'(pc_out), 32'h4); out_chk("c2", 1'b1, 16'hF120, 16'h0);
        tick(); out_chk("c3", 1'b1, 16'hF121, 16'h2);
        tick(); out_chk("c4", 1'b1, 16'h93FF, 16'h4); chk("c4.pc_out", 32'(pc_out), 32'h8);
        stall = 1'b1;
        tick(); out_chk("c5", 1'b1, 16'h93FF, 16'h4); chk("c5.pc_out", 32'(pc_out), 32'h8);
        tick(); out_chk("c6", 1'b1, 16'h93FF, 16'h4);
        tick(); out_chk("c7", 1'b1, 16'h93FF, 16'h4); chk("c7.pc_out", 32'(pc_out), 32'h8);
        stall = 1'b0;
        tick(); out_chk("c8", 1'b1, 16'h834C, 16'h6);
        tick(); out_chk("c9", 1'b1, 16'hF564, 16'h8); chk("c9.pc_out", 32'(pc_out), 32'hC);
        branch_taken = 1'b1; branch_target = 16'h000D;
        tick(); chk("c10.pc_out", 32'(pc_out), 32'hC); out_chk("c10", 1'b0, 0, 0);
        branch_taken = 1'b0;
        tick(); out_chk("c11", 1'b0, 0, 0);
        tick(); out_chk("c12", 1'b1, 16'hFFF1, 16'hC);
        branch_taken = 1'b1; branch_target = 16'h007A;
        tick(); chk("c13.pc_out", 32'(pc_out), 32'h7A);
        branch_taken = 1'b0;
        tick(); chk("c14.pc_out", 32'(pc_out), 32'h7C);
        tick(); chk("c15.pc_out", 32'(pc_out), 32'h7E); out_chk("c15", 1'b1, 16'h103D, 16'h7A);
        tick(); chk("c16.pc_out", 32'(pc_out), 32'h0); out_chk("c16", 1'b1, 16'h103E, 16'h7C);
        tick(); out_chk("c17", 1'b1, 16'h103F, 16'h7E);
        tick(); out_chk("c18", 1'b1, 16'hF120, 16'h0);
        branch_taken = 1'b1; branch_target = 16'h0035;
        tick(); chk("c19.pc_out", 32'(pc_out), 32'h34);
        branch_taken = 1'b0;
        tick(); out_chk("c20", 1'b0, 0, 0);
        tick(); out_chk("c21", 1'b1, 16'h101A, 16'h34);
        tick(); out_chk("c22", 1'b1, 16'hEFFF, 16'h36); chk("c22.halted", 32'(halted), 32'h0);
        stall = 1'b1;
        tick(); out_chk("c23", 1'b1, 16'hEFFF, 16'h36); chk("c23.halted", 32'(halted), 32'h0);
        stall = 1'b0;
        tick(); out_chk("c24", 1'b0, 0, 0); chk("c24.halted", 32'(halted), 32'h1);
        chk("c24.pc_out", 32'(pc_out), 32'h38);
        branch_taken = 1'b1; branch_target = 16'h0000;
        tick(); chk("c25.pc_out", 32'(pc_out), 32'h38); chk("c25.halted", 32'(halted), 32'h1);
        out_chk("c25", 1'b0, 0, 0);
        branch_taken = 1'b0; rst = 1'b1;
        tick(); rst_chk("halt_rst");
        rst = 1'b0;
        tick(); tick(); out_chk("r2", 1'b1, 16'hF120, 16'h0);
        stall = 1'b1;
        tick(); out_chk("r3", 1'b1, 16'hF120, 16'h0); chk("r3.pc_out", 32'(pc_out), 32'h4);
        rst = 1'b1;
        tick(); rst_chk("stall_rst");
        rst = 1'b0; stall = 1'b0;
        tick(); out_chk("s1", 1'b0, 0, 0);
        tick(); out_chk("s2", 1'b1, 16'hF120, 16'h0);
        tick(); out_chk("s3", 1'b1, 16'hF121, 16'h2);
        branch_taken = 1'b1; branch_target = 16'h0034;
        tick(); branch_taken = 1'b0;
        tick(); tick(); out_chk("s6", 1'b1, 16'h101A, 16'h34);
        branch_taken = 1'b1; branch_target = 16'h0000;
        tick(); branch_taken = 1'b0;
        chk("s7.pc_out", 32'(pc_out), 32'h0); chk("s7.halted", 32'(halted), 32'h0);
        out_chk("s7", 1'b0, 0, 0);
        tick(); chk("s8.halted", 32'(halted), 32'h0);
        tick(); out_chk("s9", 1'b1, 16'hF120, 16'h0); chk("s9.halted", 32'(halted), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
